buscaminas_ctrl: RTL and testbench
==================================

# buscaminas_ctrl

Game sequencer for the 8x8 minesweeper board. It owns the board-cell memory through a single combinational-read/synchronous-write port. It clears the board and places mines with an LFSR, maintaining neighbour counts as it goes. It then moves a cursor, toggles flags, reveals cells, flood-fills zero regions and declares win or loss. It sits between the debounced button/switch front end and the board RAM that the display path reads.

## Interface
- `N_CELLS`, 64: board size (8x8, fixed geometry).
- `LFSR_SEED`, 8'hA5: non-zero reset value of the mine-placement LFSR.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `bombs`  in  8  requested mine count; sampled when `str` is accepted.
- `str`  in  1  start/restart pulse.
- `move`  in  1  one-cycle pulse; moves the cursor one cell in direction `course`.
- `course`  in  2  direction code: 00 up, 01 down, 10 left, 11 right.
- `select`  in  1  one-cycle pulse; reveals the cell under the cursor.
- `mark`  in  1  one-cycle pulse; toggles the flag on the cell under the cursor.
- `cell_addr`  out  6  board address = row*8 + col.
- `cell_rdata`  in  8  combinational read of `cell_addr`.
- `cell_wr`  out  1  write strobe.
- `cell_wdata`  out  8  write data.
- `cur_row`, `cur_col`  out  3 each  cursor position.
- `busy`  out  1  high in CLEAR, PLACE_*, FLOOD_*.
- `game_over`  out  1  high in LOSE.
- `win`  out  1  high in WIN.

## Operation
- Cell encoding:
  - bit7 = mine; bit6 = revealed; bit5 = flagged; bits3:0 = neighbour count (0–8).
  - bit4 is always 0.
- Mine count `nb` = clamp(`bombs`, 1, 63).
- States and transitions:
  - IDLE → CLEAR on `str`.
  - CLEAR writes 8'h00 to addresses 0..63, one per cycle, then → PLACE_PICK.
  - PLACE_PICK:
    - Candidate address = `lfsr[5:0]`.
    - If the candidate's mine bit is already set, retry next cycle.
    - Otherwise write the mine bit, placed++, and → PLACE_NBR.
  - PLACE_NBR:
    - Takes exactly 8 cycles, one per neighbour slot, in order NW, N, NE, W, E, SW, S, SE.
    - An in-bounds neighbour gets a read-modify-write with count+1; an out-of-bounds slot does no write.
    - Then → PLACE_PICK if placed<nb, else PLAY.
  - PLAY:
    - `move` updates the cursor; it saturates at edges (no wrap).
    - `mark` on an unrevealed cell toggles bit5; on a revealed cell it is ignored.
    - `select` on a flagged or revealed cell is ignored.
    - `select` on a mine sets bit6 and → LOSE.
    - Otherwise `select` sets bit6 and revealed_cnt++. Then, if count==0 → FLOOD_SCAN; else run the win check.
  - FLOOD_SCAN:
    - Visits addresses 0..63 at one cycle each.
    - A cell that is revealed, not a mine, with count 0 → FLOOD_NBR.
    - At the end of a pass: if `changed`, clear it and start a new pass; else run the win check.
  - FLOOD_NBR:
    - Takes 8 cycles in the same slot order as PLACE_NBR.
    - A neighbour that is in-bounds, unrevealed, unflagged and not a mine gets bit6 set, revealed_cnt++ and `changed`=1.
    - Then the scan resumes at the next address.
  - Win check: revealed_cnt == 64−nb → WIN, else → PLAY.
  - WIN/LOSE → CLEAR on `str`.
  - PLAY → CLEAR on `str` (restart).
  - `str` is ignored while `busy`.
- Simultaneous pulses in PLAY: priority is `str` > `select` > `mark` > `move`; lower-priority pulses in the same cycle are dropped.
- Pulses arriving while `busy`, or while in IDLE/WIN/LOSE (except `str`), are dropped.

## Timing
- Reset values:
  - state IDLE, cursor (0,0), lfsr=`LFSR_SEED`.
  - `busy`, `game_over`, `win`, `cell_wr` = 0; `cell_addr`=0; `cell_wdata`=0; counters 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle after reset regardless of state.
- Latencies:
  - CLEAR takes 64 cycles.
  - Each accepted mine costs 1+8 cycles; each rejected pick costs 1 cycle.
  - A cursor update is visible the cycle after `move`.
  - A cell write lands on the edge after the strobe.
  - `game_over`/`win` rise the cycle after the deciding write.
- Reset mid-operation: it takes effect on the next edge; partial board contents are left as-is; state returns to IDLE.

## Structure
- `buscaminas_pkg` holds:
  - the state enum;
  - cell bit-position constants;
  - direction codes;
  - the neighbour offset/bounds function (row/col ±1 with an 8x8 check).
- One sub-module: `lfsr8` (seed parameter, enable, 8-bit state out).
- Board RAM is external and owned by the top-level/bench.

## Test plan
- Reset with `rst`=0 for 2 cycles → all outputs at reset values; state IDLE; no `cell_wr`.
- `str` with `bombs`=0 → 64 zero writes, then exactly one mine bit set in RAM. Every in-bounds neighbour of the mine has count 1; all other non-mine cells have count 0. `busy` falls on entry to PLAY.
- `str` with `bombs`=200 → exactly 63 mines.
- In PLAY: 10× `move` with `course`=11 → `cur_col`=7; 3× up from row 0 → `cur_row`=0.
- Backdoor board (bench overwrites RAM after `busy` falls): single mine at address 63, counts set accordingly.
  - `select` at (0,0) → flood reveals all 63 non-mine cells; `win`=1; `game_over`=0.
- `mark` at (2,2), then `select` at (2,2) → bit5 set, bit6 stays 0, state PLAY.
- `mark` again, then `select` on a mine cell → bit6 set; `game_over`=1 the next cycle.
- `str` and `select` asserted in the same PLAY cycle → CLEAR entered; no reveal write.

Source files
------------

// File: rtl/buscaminas_pkg.sv
// rtl/buscaminas_pkg.sv - shared types, cell layout, directions and neighbour helper
// Contents:
//   state_e      : sequencer states
//   BIT_*/ *_M   : cell bit positions and masks
//   DIR_*        : cursor direction codes
//   nbr_t/nbr_of : neighbour slot -> {valid, address} for an 8x8 board
//   clamp_bombs  : requested mine count clamped to 1..63
package buscaminas_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_PLACE_PICK,
    S_PLACE_NBR,
    S_PLAY,
    S_FLOOD_SCAN,
    S_FLOOD_NBR,
    S_WIN,
    S_LOSE
  } state_e;

  localparam int BIT_MINE = 7;
  localparam int BIT_REV  = 6;
  localparam int BIT_FLAG = 5;

  localparam logic [7:0] MINE_M = 8'h80;
  localparam logic [7:0] REV_M  = 8'h40;
  localparam logic [7:0] FLAG_M = 8'h20;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [5:0] addr;
  } nbr_t;

  // Slots 0..7 are NW, N, NE, W, E, SW, S, SE. Each slot maps onto a 3x3
  // grid index k (centre k=4 skipped); row/col are offset by +1 so the
  // bounds check never needs signed arithmetic.
  function automatic nbr_t nbr_of(input logic [5:0] addr, input logic [2:0] slot);
    logic [3:0] k, rr, cc;
    nbr_t       n;
    k  = (slot < 3'd4) ? {1'b0, slot} : {1'b0, slot} + 4'd1;
    rr = {1'b0, addr[5:3]} + (k / 4'd3);
    cc = {1'b0, addr[2:0]} + (k % 4'd3);
    n.valid = (rr != 4'd0) && (rr <= 4'd8) && (cc != 4'd0) && (cc <= 4'd8);
    n.addr  = {rr[2:0] - 3'd1, cc[2:0] - 3'd1};
    return n;
  endfunction

  function automatic logic [5:0] clamp_bombs(input logic [7:0] b);
    if (b == 8'd0)       return 6'd1;
    else if (b > 8'd63)  return 6'd63;
    else                 return b[5:0];
  endfunction

endpackage

// File: rtl/buscaminas_lfsr8.sv
// rtl/buscaminas_lfsr8.sv - 8-bit Fibonacci LFSR, taps 8,6,5,4
// Ports:
//   clk, rst : clock, synchronous active-low reset (loads SEED)
//   en_i     : advance one step
//   state_o  : current 8-bit state
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/buscaminas_ctrl.sv
// rtl/buscaminas_ctrl.sv - minesweeper game sequencer driving the external board RAM
// Ports:
//   clk, rst                   : clock, synchronous active-low reset
//   bombs, str                 : mine count request, start/restart pulse
//   move, course, select, mark : play pulses and cursor direction
//   cell_addr/rdata/wr/wdata   : board RAM port (combinational read, write on next edge)
//   cur_row, cur_col           : cursor position
//   busy, game_over, win       : status
module buscaminas_ctrl
  import buscaminas_pkg::*;
#(
  parameter int         N_CELLS   = 64,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bombs,
  input  logic       str,
  input  logic       move,
  input  logic [1:0] course,
  input  logic       select,
  input  logic       mark,
  output logic [5:0] cell_addr,
  input  logic [7:0] cell_rdata,
  output logic       cell_wr,
  output logic [7:0] cell_wdata,
  output logic [2:0] cur_row,
  output logic [2:0] cur_col,
  output logic       busy,
  output logic       game_over,
  output logic       win
);

  localparam logic [5:0] LAST_ADDR = 6'(N_CELLS - 1);
  localparam logic [6:0] CELLS_W   = 7'(N_CELLS);

  state_e     state_q, state_d;
  logic [5:0] idx_q, idx_d, center_q, center_d, placed_q, placed_d, nb_q, nb_d;
  logic [2:0] slot_q, slot_d, row_q, row_d, col_q, col_d;
  logic [6:0] rev_q, rev_d;
  logic       changed_q, changed_d;

  logic [7:0] lfsr;
  logic [1:0] unused_lfsr_hi;
  nbr_t       nbr;
  logic       accept_start, pass_end;
  logic       c_mine, c_rev, c_flag, c_zero;
  logic [6:0] target;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (1'b1),
    .state_o (lfsr)
  );

  assign unused_lfsr_hi = lfsr[7:6];
  assign c_mine = cell_rdata[BIT_MINE];
  assign c_rev  = cell_rdata[BIT_REV];
  assign c_flag = cell_rdata[BIT_FLAG];
  assign c_zero = (cell_rdata[3:0] == 4'd0);
  assign target = CELLS_W - {1'b0, nb_q};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    center_d     = center_q;
    placed_d     = placed_q;
    nb_d         = nb_q;
    slot_d       = slot_q;
    row_d        = row_q;
    col_d        = col_q;
    rev_d        = rev_q;
    changed_d    = changed_q;
    cell_addr    = 6'd0;
    cell_wr      = 1'b0;
    cell_wdata   = 8'd0;
    accept_start = 1'b0;
    pass_end     = 1'b0;
    nbr          = nbr_of(center_q, slot_q);

    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: accept_start = str;

      S_CLEAR: begin
        cell_addr = idx_q;
        cell_wr   = 1'b1;
        idx_d     = idx_q + 6'd1;
        if (idx_q == LAST_ADDR) state_d = S_PLACE_PICK;
      end

      S_PLACE_PICK: begin
        cell_addr = lfsr[5:0];
        if (!c_mine) begin
          cell_wr    = 1'b1;
          cell_wdata = cell_rdata | MINE_M;
          placed_d   = placed_q + 6'd1;
          center_d   = lfsr[5:0];
          slot_d     = 3'd0;
          state_d    = S_PLACE_NBR;
        end
      end

      S_PLACE_NBR: begin
        if (nbr.valid) begin
          cell_addr  = nbr.addr;
          cell_wr    = 1'b1;
          cell_wdata = cell_rdata + 8'd1;
        end
        slot_d = slot_q + 3'd1;
        if (slot_q == 3'd7) state_d = (placed_q < nb_q) ? S_PLACE_PICK : S_PLAY;
      end

      S_PLAY: begin
        cell_addr = {row_q, col_q};
        if (str) begin
          accept_start = 1'b1;
        end else if (select) begin
          if (!c_flag && !c_rev) begin
            cell_wr    = 1'b1;
            cell_wdata = cell_rdata | REV_M;
            if (c_mine) begin
              state_d = S_LOSE;
            end else begin
              rev_d = rev_q + 7'd1;
              if (c_zero) begin
                idx_d     = 6'd0;
                changed_d = 1'b0;
                state_d   = S_FLOOD_SCAN;
              end else begin
                state_d = (rev_q + 7'd1 == target) ? S_WIN : S_PLAY;
              end
            end
          end
        end else if (mark) begin
          if (!c_rev) begin
            cell_wr    = 1'b1;
            cell_wdata = cell_rdata ^ FLAG_M;
          end
        end else if (move) begin
          unique case (course)
            DIR_UP:    if (row_q != 3'd0) row_d = row_q - 3'd1;
            DIR_DOWN:  if (row_q != 3'd7) row_d = row_q + 3'd1;
            DIR_LEFT:  if (col_q != 3'd0) col_d = col_q - 3'd1;
            DIR_RIGHT: if (col_q != 3'd7) col_d = col_q + 3'd1;
            default: ;
          endcase
        end
      end

      S_FLOOD_SCAN: begin
        cell_addr = idx_q;
        if (c_rev && !c_mine && c_zero) begin
          center_d = idx_q;
          slot_d   = 3'd0;
          state_d  = S_FLOOD_NBR;
        end else if (idx_q == LAST_ADDR) begin
          pass_end = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end

      S_FLOOD_NBR: begin
        if (nbr.valid) begin
          cell_addr = nbr.addr;
          if (!c_rev && !c_flag && !c_mine) begin
            cell_wr    = 1'b1;
            cell_wdata = cell_rdata | REV_M;
            rev_d      = rev_q + 7'd1;
            changed_d  = 1'b1;
          end
        end
        slot_d = slot_q + 3'd1;
        if (slot_q == 3'd7) begin
          // The scan resumes after the centre; a centre at the last address
          // closes the pass here rather than costing an extra scan cycle.
          if (center_q == LAST_ADDR) pass_end = 1'b1;
          else begin
            idx_d   = center_q + 6'd1;
            state_d = S_FLOOD_SCAN;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (pass_end) begin
      if (changed_d) begin
        changed_d = 1'b0;
        idx_d     = 6'd0;
        state_d   = S_FLOOD_SCAN;
      end else begin
        state_d = (rev_d == target) ? S_WIN : S_PLAY;
      end
    end

    if (accept_start) begin
      state_d   = S_CLEAR;
      idx_d     = 6'd0;
      placed_d  = 6'd0;
      rev_d     = 7'd0;
      changed_d = 1'b0;
      nb_d      = clamp_bombs(bombs);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 6'd0;
      center_q  <= 6'd0;
      placed_q  <= 6'd0;
      nb_q      <= 6'd0;
      slot_q    <= 3'd0;
      row_q     <= 3'd0;
      col_q     <= 3'd0;
      rev_q     <= 7'd0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      center_q  <= center_d;
      placed_q  <= placed_d;
      nb_q      <= nb_d;
      slot_q    <= slot_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rev_q     <= rev_d;
      changed_q <= changed_d;
    end
  end

  assign cur_row   = row_q;
  assign cur_col   = col_q;
  assign busy      = (state_q == S_CLEAR) || (state_q == S_PLACE_PICK) || (state_q == S_PLACE_NBR) ||
                     (state_q == S_FLOOD_SCAN) || (state_q == S_FLOOD_NBR);
  assign game_over = (state_q == S_LOSE);
  assign win       = (state_q == S_WIN);

endmodule

// File: tb/tb_buscaminas_ctrl.sv
// tb/tb_buscaminas_ctrl.sv - randomized self-checking bench with a behavioural game model
module tb_buscaminas_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] bombs = 8'd0;
  logic       str = 1'b0, move = 1'b0, select = 1'b0, mark = 1'b0;
  logic [1:0] course = 2'b00;
  logic [5:0] cell_addr;
  logic [7:0] cell_rdata, cell_wdata;
  logic       cell_wr;
  logic [2:0] cur_row, cur_col;
  logic       busy, game_over, win;

  always #5 clk = ~clk;

  buscaminas_ctrl dut (
    .clk(clk), .rst(rst), .bombs(bombs), .str(str), .move(move), .course(course),
    .select(select), .mark(mark), .cell_addr(cell_addr), .cell_rdata(cell_rdata),
    .cell_wr(cell_wr), .cell_wdata(cell_wdata), .cur_row(cur_row), .cur_col(cur_col),
    .busy(busy), .game_over(game_over), .win(win)
  );

  logic [7:0] ram    [64];
  logic [7:0] bd_img [64];
  logic       bd_load = 1'b0;

  always @(posedge clk) begin
    if (bd_load) for (int i = 0; i < 64; i++) ram[i] <= bd_img[i];
    else if (cell_wr) ram[cell_addr] <= cell_wdata;
  end
  assign cell_rdata = ram[cell_addr];

  int n_chk = 0, n_fail = 0;
  logic [7:0] mdl [64];
  int exp_row = 0, exp_col = 0, nb_exp = 1;
  bit exp_win = 0, exp_lose = 0, chk_cur = 0, chk_st = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_cur) begin
      check("cur_row", int'(cur_row), exp_row);
      check("cur_col", int'(cur_col), exp_col);
    end
    if (chk_st) begin
      check("busy_idle", int'(busy), 0);
      check("win", int'(win), int'(exp_win));
      check("game_over", int'(game_over), int'(exp_lose));
    end
  end

  function automatic bit inb(input int r, input int c);
    return r >= 0 && r < 8 && c >= 0 && c < 8;
  endfunction

  function automatic int count_mines();
    int n = 0;
    for (int a = 0; a < 64; a++) if (ram[a][7]) n++;
    return n;
  endfunction

  // Cells whose count field disagrees with the mines around them, or that carry
  // revealed/flag/bit4 right after placement.
  function automatic int bad_counts();
    int bad = 0;
    for (int a = 0; a < 64; a++) begin
      int n = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if ((dr != 0 || dc != 0) && inb(a / 8 + dr, a % 8 + dc) && ram[(a / 8 + dr) * 8 + a % 8 + dc][7]) n++;
      if (int'(ram[a][3:0]) != n || ram[a][6:4] != 3'b000) bad++;
    end
    return bad;
  endfunction

  function automatic int board_diff();
    int d = 0;
    for (int a = 0; a < 64; a++) if (ram[a] !== mdl[a]) d++;
    return d;
  endfunction

  function automatic int revealed_cnt();
    int n = 0;
    for (int a = 0; a < 64; a++) if (mdl[a][6]) n++;
    return n;
  endfunction

  // Reveal fixpoint: any revealed safe zero cell exposes its hidden, unflagged safe neighbours.
  task automatic model_flood();
    bit ch;
    do begin
      ch = 0;
      for (int a = 0; a < 64; a++)
        if (mdl[a][6] && !mdl[a][7] && mdl[a][3:0] == 4'd0)
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if ((dr != 0 || dc != 0) && inb(a / 8 + dr, a % 8 + dc)) begin
                int b = (a / 8 + dr) * 8 + a % 8 + dc;
                if (!mdl[b][6] && !mdl[b][5] && !mdl[b][7]) begin
                  mdl[b][6] = 1'b1;
                  ch = 1;
                end
              end
    end while (ch);
  endtask

  task automatic model_select(input int a);
    if (mdl[a][5] || mdl[a][6]) return;
    mdl[a][6] = 1'b1;
    if (mdl[a][7]) begin
      exp_lose = 1;
      return;
    end
    if (mdl[a][3:0] == 4'd0) model_flood();
    exp_win = (revealed_cnt() == 64 - nb_exp);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 30000) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("busy_timeout", 1, 0);
  endtask

  task automatic pulse_move(input logic [1:0] d);
    @(negedge clk);
    move = 1'b1;
    course = d;
    @(posedge clk);
    #1;
    case (d)
      2'b00: if (exp_row > 0) exp_row--;
      2'b01: if (exp_row < 7) exp_row++;
      2'b10: if (exp_col > 0) exp_col--;
      default: if (exp_col < 7) exp_col++;
    endcase
    @(negedge clk);
    move = 1'b0;
  endtask

  task automatic pulse_mark();
    int a;
    @(negedge clk);
    mark = 1'b1;
    @(posedge clk);
    #1;
    a = exp_row * 8 + exp_col;
    if (!mdl[a][6]) mdl[a][5] = ~mdl[a][5];
    @(negedge clk);
    mark = 1'b0;
    check("board_after_mark", board_diff(), 0);
  endtask

  task automatic pulse_select();
    chk_st = 0;
    @(negedge clk);
    select = 1'b1;
    @(posedge clk);
    #1;
    model_select(exp_row * 8 + exp_col);
    @(negedge clk);
    select = 1'b0;
    wait_idle();
    chk_st = 1;
    check("board_after_select", board_diff(), 0);
  endtask

  task automatic do_start(input int b, output int busy_cyc, output int clear_bad, output int n_wr);
    int k = 0;
    busy_cyc = 0;
    clear_bad = 0;
    n_wr = 0;
    chk_st = 0;
    @(negedge clk);
    str = 1'b1;
    bombs = 8'(b);
    @(posedge clk);
    #1;
    exp_win = 0;
    exp_lose = 0;
    nb_exp = (b < 1) ? 1 : (b > 63) ? 63 : b;
    @(negedge clk);
    str = 1'b0;
    while (busy && k < 30000) begin
      busy_cyc++;
      if (cell_wr) begin
        if (n_wr < 64 && (int'(cell_addr) != n_wr || cell_wdata != 8'd0)) clear_bad++;
        n_wr++;
      end
      @(negedge clk);
      k++;
    end
    if (busy) check("start_timeout", 1, 0);
    check("placed_mines", count_mines(), nb_exp);
    check("placed_counts_bad", bad_counts(), 0);
    for (int a = 0; a < 64; a++) mdl[a] = ram[a];
    chk_st = 1;
  endtask

  // One mine in the bottom-right corner; its three neighbours count 1.
  task automatic load_corner_board();
    for (int a = 0; a < 64; a++) bd_img[a] = 8'h00;
    bd_img[63] = 8'h80;
    bd_img[54] = 8'h01;
    bd_img[55] = 8'h01;
    bd_img[62] = 8'h01;
    @(negedge clk);
    bd_load = 1'b1;
    @(negedge clk);
    bd_load = 1'b0;
    for (int a = 0; a < 64; a++) mdl[a] = bd_img[a];
  endtask

  initial begin
    int bc, cb, nw, exp_nbr, mine_a;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_win", int'(win), 0);
    check("rst_cell_wr", int'(cell_wr), 0);
    check("rst_cell_addr", int'(cell_addr), 0);
    check("rst_cell_wdata", int'(cell_wdata), 0);
    check("rst_cur_row", int'(cur_row), 0);
    check("rst_cur_col", int'(cur_col), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_no_write", int'(cell_wr), 0);
    chk_cur = 1;

    // bombs=0 clamps to a single mine: 64 clears, one pick, eight slots.
    do_start(0, bc, cb, nw);
    check("single_busy_cycles", bc, 73);
    check("clear_writes_bad", cb, 0);
    mine_a = 0;
    for (int a = 0; a < 64; a++) if (ram[a][7]) mine_a = a;
    exp_nbr = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if ((dr != 0 || dc != 0) && inb(mine_a / 8 + dr, mine_a % 8 + dc)) exp_nbr++;
    check("single_write_count", nw, 64 + 1 + exp_nbr);

    repeat (10) pulse_move(2'b11);
    check("sat_right_col", int'(cur_col), 7);
    repeat (3) pulse_move(2'b00);
    check("sat_up_row", int'(cur_row), 0);
    for (int i = 0; i < 30; i++) pulse_move(2'($urandom_range(0, 3)));

    do_start(200, bc, cb, nw);
    check("max_mines", count_mines(), 63);

    for (int g = 0; g < 3; g++) begin
      do_start($urandom_range(1, 10), bc, cb, nw);
      for (int op = 0; op < 25 && !exp_win && !exp_lose; op++) begin
        int nm = $urandom_range(0, 3);
        for (int m = 0; m < nm; m++) pulse_move(2'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) pulse_mark();
        else pulse_select();
      end
    end

    // Flood from the far corner must expose every safe cell and win.
    do_start(1, bc, cb, nw);
    load_corner_board();
    repeat (8) pulse_move(2'b00);
    repeat (8) pulse_move(2'b10);
    pulse_select();
    check("flood_win", int'(win), 1);
    check("flood_no_game_over", int'(game_over), 0);
    check("flood_revealed", revealed_cnt(), 63);

    // Flag blocks select; unflag, then hit the mine.
    do_start(1, bc, cb, nw);
    load_corner_board();
    repeat (8) pulse_move(2'b00);
    repeat (8) pulse_move(2'b10);
    repeat (2) pulse_move(2'b01);
    repeat (2) pulse_move(2'b11);
    pulse_mark();
    check("flag_set", int'(ram[18][5]), 1);
    pulse_select();
    check("flagged_not_revealed", int'(ram[18][6]), 0);
    check("flagged_still_play", int'(game_over | win), 0);
    pulse_mark();
    check("flag_cleared", int'(ram[18][5]), 0);
    repeat (5) pulse_move(2'b01);
    repeat (5) pulse_move(2'b11);
    chk_st = 0;
    @(negedge clk);
    select = 1'b1;
    #1;
    check("mine_reveal_strobe", int'(cell_wr), 1);
    check("mine_reveal_data", int'(cell_wdata), 8'hC0);
    check("game_over_before_edge", int'(game_over), 0);
    @(posedge clk);
    #1;
    check("game_over_next_cycle", int'(game_over), 1);
    model_select(63);
    @(negedge clk);
    select = 1'b0;
    chk_st = 1;
    @(negedge clk);
    check("board_after_lose", board_diff(), 0);

    // str outranks select in the same PLAY cycle.
    do_start(1, bc, cb, nw);
    chk_st = 0;
    @(negedge clk);
    str = 1'b1;
    select = 1'b1;
    bombs = 8'd1;
    #1;
    check("str_select_no_write", int'(cell_wr), 0);
    @(posedge clk);
    #1;
    check("str_select_busy", int'(busy), 1);
    @(negedge clk);
    str = 1'b0;
    select = 1'b0;
    wait_idle();
    check("restart_mines", count_mines(), 1);
    chk_cur = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
